addsub_accum: RTL and testbench



---
 rtl/addsub_accum.sv | 205 ++++++++++++++++++++
 tb/tb_addsub_accum.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accum.sv
// addsub_accum: register/control stage around the ripple adder/subtractor addsub32.
//
// A command (ADD, SUB, LOAD, CLEAR) is taken over a valid/ready handshake.
// LOAD and CLEAR complete on the accept edge. ADD/SUB launch the accumulator
// and a registered operand into addsub32. The block then waits SETTLE_CYCLES
// clock edges for the ripple chain to settle before capturing the result.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   command present
//   in_ready   block can accept a command (IDLE and not in reset)
//   in_op      00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   in_data    operand for ADD/SUB, value for LOAD
//   acc        accumulator (registered)
//   carry      registered cout of last ADD/SUB (SUB: 1 = no borrow)
//   ovf        registered signed overflow of last ADD/SUB
//   sticky_ovf OR of all ovf since last CLEAR/reset
//   out_valid  one-cycle completion pulse
//   busy       ADD/SUB in flight
//   op_count   completed ADD/SUB count, wraps

// addsub32: combinational 32-bit ripple-carry adder/subtractor.
// SUB=1 computes A-B as A + ~B + 1. V is signed overflow.
module addsub32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        SUB,
    output logic [31:0] ans,
    output logic        cout,
    output logic        V
);
    logic [32:0] c_s;
    logic [31:0] bx_s;

    assign bx_s   = B ^ {32{SUB}};
    assign c_s[0] = SUB;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign ans[i]   = A[i] ^ bx_s[i] ^ c_s[i];
        assign c_s[i+1] = (A[i] & bx_s[i]) | (c_s[i] & (A[i] ^ bx_s[i]));
    end

    assign cout = c_s[32];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign V    = c_s[32] ^ c_s[31];
endmodule

module addsub_accum #(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_data,
    output logic [31:0]      acc,
    output logic             carry,
    output logic             ovf,
    output logic             sticky_ovf,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Counter only has to hold SETTLE_CYCLES-1.
    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [31:0]        opnd_r, opnd_s;
    logic               sub_r, sub_s;
    logic [31:0]        acc_r, acc_s;
    logic               carry_r, carry_s;
    logic               ovf_r, ovf_s;
    logic               sticky_r, sticky_s;
    logic               outv_r, outv_s;
    logic [CNT_W-1:0]   opcnt_r, opcnt_s;

    logic [31:0]        ans_s;
    logic               cout_s;
    logic               v_s;

    // Adder inputs come straight from registers that are frozen during SETTLE.
    addsub32 u_addsub32 (
        .A    (acc_r),
        .B    (opnd_r),
        .SUB  (sub_r),
        .ans  (ans_s),
        .cout (cout_s),
        .V    (v_s)
    );

    // Next-state and datapath update for command accept and result capture.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        opnd_s   = opnd_r;
        sub_s    = sub_r;
        acc_s    = acc_r;
        carry_s  = carry_r;
        ovf_s    = ovf_r;
        sticky_s = sticky_r;
        outv_s   = 1'b0;
        opcnt_s  = opcnt_r;

        case (state_r)
            IDLE: begin
                // in_ready is high throughout IDLE outside reset, so in_valid alone accepts.
                if (in_valid) begin
                    case (in_op)
                        OP_ADD, OP_SUB: begin
                            opnd_s  = in_data;
                            sub_s   = in_op[0];
                            cnt_s   = CNT_INIT;
                            state_s = SETTLE;
                        end
                        OP_LOAD: begin
                            acc_s   = in_data;
                            carry_s = 1'b0;
                            ovf_s   = 1'b0;
                            outv_s  = 1'b1;
                        end
                        OP_CLEAR: begin
                            acc_s    = 32'h0000_0000;
                            carry_s  = 1'b0;
                            ovf_s    = 1'b0;
                            sticky_s = 1'b0;
                            outv_s   = 1'b1;
                        end
                        default: begin
                            state_s = IDLE;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CW'(1);
                end else begin
                    acc_s    = ans_s;
                    carry_s  = cout_s;
                    ovf_s    = v_s;
                    sticky_s = sticky_r | v_s;
                    opcnt_s  = opcnt_r + CNT_W'(1);
                    outv_s   = 1'b1;
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            opnd_r   <= 32'h0000_0000;
            sub_r    <= 1'b0;
            acc_r    <= 32'h0000_0000;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            sticky_r <= 1'b0;
            outv_r   <= 1'b0;
            opcnt_r  <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            opnd_r   <= opnd_s;
            sub_r    <= sub_s;
            acc_r    <= acc_s;
            carry_r  <= carry_s;
            ovf_r    <= ovf_s;
            sticky_r <= sticky_s;
            outv_r   <= outv_s;
            opcnt_r  <= opcnt_s;
        end
    end

    assign in_ready   = (state_r == IDLE) && !rst;
    assign busy       = (state_r == SETTLE);
    assign acc        = acc_r;
    assign carry      = carry_r;
    assign ovf        = ovf_r;
    assign sticky_ovf = sticky_r;
    assign out_valid  = outv_r;
    assign op_count   = opcnt_r;
endmodule

// File: tb/tb_addsub_accum.sv
module tb_addsub_accum;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [31:0] in_data;

    // Index 0: SETTLE_CYCLES=8, index 1: SETTLE_CYCLES=1. Both see the same stimulus.
    logic        d_rdy[2], d_carry[2], d_ovf[2], d_sticky[2], d_outv[2], d_busy[2];
    logic [31:0] d_acc[2];
    logic [15:0] d_cnt[2];

    int n_chk = 0, n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    addsub_accum #(.SETTLE_CYCLES(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_rdy[0]), .in_op(in_op),
        .in_data(in_data), .acc(d_acc[0]), .carry(d_carry[0]), .ovf(d_ovf[0]),
        .sticky_ovf(d_sticky[0]), .out_valid(d_outv[0]), .busy(d_busy[0]), .op_count(d_cnt[0]));

    addsub_accum #(.SETTLE_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_rdy[1]), .in_op(in_op),
        .in_data(in_data), .acc(d_acc[1]), .carry(d_carry[1]), .ovf(d_ovf[1]),
        .sticky_ovf(d_sticky[1]), .out_valid(d_outv[1]), .busy(d_busy[1]), .op_count(d_cnt[1]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int settle_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    // Returns {ovf, carry, sum} of a +/- b in 32-bit two's complement.
    function automatic logic [33:0] arith(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] s;
        logic        v;
        if (sub) s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else     s = {1'b0, a} + {1'b0, b};
        if (sub) v = (a[31] != b[31]) && (s[31] != a[31]);
        else     v = (a[31] == b[31]) && (s[31] != a[31]);
        return {v, s};
    endfunction

    logic [31:0] m_acc[2];
    logic        m_carry[2], m_ovf[2], m_sticky[2], m_outv[2], m_busy[2];
    logic [33:0] m_res[2];
    int          m_rem[2];
    logic [15:0] m_cnt[2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_acc[k] <= 32'd0; m_carry[k] <= 1'b0; m_ovf[k] <= 1'b0; m_sticky[k] <= 1'b0;
                m_outv[k] <= 1'b0; m_busy[k] <= 1'b0; m_rem[k] <= 0; m_cnt[k] <= 16'd0;
                m_res[k] <= 34'd0;
            end else begin
                m_outv[k] <= 1'b0;
                if (m_busy[k]) begin
                    if (m_rem[k] == 1) begin
                        m_acc[k]    <= m_res[k][31:0];
                        m_carry[k]  <= m_res[k][32];
                        m_ovf[k]    <= m_res[k][33];
                        m_sticky[k] <= m_sticky[k] | m_res[k][33];
                        m_cnt[k]    <= m_cnt[k] + 16'd1;
                        m_outv[k]   <= 1'b1;
                        m_busy[k]   <= 1'b0;
                    end else begin
                        m_rem[k] <= m_rem[k] - 1;
                    end
                end else if (in_valid) begin
                    case (in_op)
                        LOAD: begin
                            m_acc[k] <= in_data; m_carry[k] <= 1'b0; m_ovf[k] <= 1'b0; m_outv[k] <= 1'b1;
                        end
                        CLR: begin
                            m_acc[k] <= 32'd0; m_carry[k] <= 1'b0; m_ovf[k] <= 1'b0;
                            m_sticky[k] <= 1'b0; m_outv[k] <= 1'b1;
                        end
                        default: begin
                            m_res[k]  <= arith(m_acc[k], in_data, in_op[0]);
                            m_rem[k]  <= settle_of(k);
                            m_busy[k] <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d_acc", k),      d_acc[k],            m_acc[k]);
                chk($sformatf("m%0d_carry", k),    32'(d_carry[k]),     32'(m_carry[k]));
                chk($sformatf("m%0d_ovf", k),      32'(d_ovf[k]),       32'(m_ovf[k]));
                chk($sformatf("m%0d_sticky", k),   32'(d_sticky[k]),    32'(m_sticky[k]));
                chk($sformatf("m%0d_outv", k),     32'(d_outv[k]),      32'(m_outv[k]));
                chk($sformatf("m%0d_busy", k),     32'(d_busy[k]),      32'(m_busy[k]));
                chk($sformatf("m%0d_ready", k),    32'(d_rdy[k]),       32'(!m_busy[k] && !rst));
                chk($sformatf("m%0d_opcount", k),  32'(d_cnt[k]),       32'(m_cnt[k]));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cmd(input logic [1:0] op, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        while (!d_rdy[0] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("cmd_ready_timeout", 32'(d_rdy[0]), 32'd1);
        in_valid = 1'b1; in_op = op; in_data = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!d_outv[0] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("done_timeout", 32'(d_outv[0]), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, pulses, accepts, bad;
        logic [15:0] base;
        in_valid = 1'b0; in_op = ADD; in_data = 32'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 chk("reset_acc", d_acc[0], 32'd0);
        chk("reset_ready", 32'(d_rdy[0]), 32'd0);
        chk("reset_outv", 32'(d_outv[0]), 32'd0);
        chk_en = 1'b1;
        #20 rst = 1'b0;

        // LOAD 5, ADD 3 with latency and busy-length measurement
        cmd(LOAD, 32'd5); wait_done();
        cmd(ADD, 32'd3);
        n = 0; nb = 0;
        do begin
            @(negedge clk); n++;
            if (d_busy[0]) nb++;
        end while (!d_outv[0] && n < 50);
        chk("t1_latency", 32'(n), 32'd9);
        chk("t1_busy_cycles", 32'(nb), 32'd8);
        chk("t1_acc", d_acc[0], 32'h0000_0008);
        chk("t1_carry", 32'(d_carry[0]), 32'd0);
        chk("t1_ovf", 32'(d_ovf[0]), 32'd0);
        chk("t1_opcount", 32'(d_cnt[0]), 32'd1);

        // Signed overflow and sticky behaviour
        cmd(LOAD, 32'h7FFF_FFFF); wait_done();
        cmd(ADD, 32'h0000_0001); wait_done();
        chk("t2_acc", d_acc[0], 32'h8000_0000);
        chk("t2_ovf", 32'(d_ovf[0]), 32'd1);
        chk("t2_sticky", 32'(d_sticky[0]), 32'd1);
        chk("t2_carry", 32'(d_carry[0]), 32'd0);
        cmd(LOAD, 32'd0); wait_done();
        chk("t2_load_ovf", 32'(d_ovf[0]), 32'd0);
        chk("t2_load_sticky", 32'(d_sticky[0]), 32'd1);
        cmd(CLR, 32'hDEAD_BEEF); wait_done();
        chk("t2_clr_sticky", 32'(d_sticky[0]), 32'd0);
        chk("t2_clr_acc", d_acc[0], 32'd0);

        // Subtraction borrow and unsigned wrap
        cmd(LOAD, 32'd5); wait_done();
        cmd(SUB, 32'd3); wait_done();
        chk("t3_sub_acc", d_acc[0], 32'd2);
        chk("t3_sub_carry", 32'(d_carry[0]), 32'd1);
        cmd(SUB, 32'd3); wait_done();
        chk("t3_borrow_acc", d_acc[0], 32'hFFFF_FFFF);
        chk("t3_borrow_carry", 32'(d_carry[0]), 32'd0);
        chk("t3_borrow_ovf", 32'(d_ovf[0]), 32'd0);
        cmd(LOAD, 32'hFFFF_FFFF); wait_done();
        cmd(ADD, 32'd1); wait_done();
        chk("t3_wrap_acc", d_acc[0], 32'd0);
        chk("t3_wrap_carry", 32'(d_carry[0]), 32'd1);
        chk("t3_wrap_ovf", 32'(d_ovf[0]), 32'd0);

        // Held in_valid with in_data toggling during SETTLE
        cmd(CLR, 32'd0); wait_done();
        base = d_cnt[0];
        in_valid = 1'b1; in_op = ADD; in_data = 32'd1;
        accepts = d_rdy[0] ? 1 : 0;
        pulses = 0; bad = 0; n = 0;
        while (pulses < 3 && n < 300) begin
            @(negedge clk); n++;
            if (d_outv[0]) pulses++;
            if (d_busy[0] && d_rdy[0]) bad++;
            if (pulses == 3) in_valid = 1'b0;
            else begin
                in_data = d_rdy[0] ? 32'd1 : 32'h55;
                if (d_rdy[0]) accepts++;
            end
        end
        in_valid = 1'b0;
        chk("t4_accepts", 32'(accepts), 32'd3);
        chk("t4_pulses", 32'(pulses), 32'd3);
        chk("t4_ready_in_settle", 32'(bad), 32'd0);
        chk("t4_acc", d_acc[0], 32'd3);
        chk("t4_opcount", 32'(d_cnt[0] - base), 32'd3);

        // Asynchronous reset in the middle of SETTLE
        cmd(ADD, 32'd5);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_acc", d_acc[0], 32'd0);
        chk("t5_rst_ready", 32'(d_rdy[0]), 32'd0);
        chk("t5_rst_busy", 32'(d_busy[0]), 32'd0);
        chk("t5_rst_opcount", 32'(d_cnt[0]), 32'd0);
        chk("t5_rst_sticky", 32'(d_sticky[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("t5_rst_outv", 32'(d_outv[0]), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        cmd(LOAD, 32'd9); wait_done();
        cmd(ADD, 32'd1);
        // SETTLE_CYCLES=1 instance: busy for one cycle, done the next
        @(negedge clk);
        chk("t6_busy1", 32'(d_busy[1]), 32'd1);
        chk("t6_ready1_low", 32'(d_rdy[1]), 32'd0);
        @(negedge clk);
        chk("t6_outv1", 32'(d_outv[1]), 32'd1);
        chk("t6_acc1", d_acc[1], 32'd10);
        chk("t6_ready1_back", 32'(d_rdy[1]), 32'd1);
        wait_done();
        chk("t5_acc", d_acc[0], 32'd10);
        chk("t5_opcount", 32'(d_cnt[0]), 32'd1);

        // Randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 99) < 60);
            in_op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: in_data = 32'h0000_0000;
                1: in_data = 32'h7FFF_FFFF;
                2: in_data = 32'h8000_0000;
                3: in_data = 32'hFFFF_FFFF;
                4: in_data = 32'h0000_0001;
                default: in_data = $urandom;
            endcase
            if ($urandom_range(0, 399) == 0) begin
                #3 rst = 1'b1;
                #4 rst = 1'b0;
            end
        end
        in_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
